imem_boot_loader: RTL

- Upstream stage of the RV32I single-cycle core.
- Receives a program image as a byte stream over a valid/ready handshake and assembles the bytes into 32-bit little-endian words.
- Writes each word into the core's instruction memory write port and holds the core in reset until the whole image has been loaded and its checksum verified.
- Replaces the bench-only $readmemh preload with a synthesizable load path.

---
 rtl/imem_boot_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Receives a length-prefixed, checksummed program image as a byte stream.
// Assembles the bytes into little-endian 32-bit words and writes each word
// to the instruction-memory write port. The core is held in reset until the
// whole image has arrived and its checksum (mod 2^32 sum of the data words)
// matches the trailer. All outputs are registered.
module imem_boot_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_WORDS  = 1024,
   parameter int START_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  core_reset,
   output logic                  done,
   output logic                  error
);

   // Word counter must be able to hold N itself (1..MAX_WORDS).
   localparam int CNT_W = $clog2(MAX_WORDS + 1);

   typedef enum logic [2:0] {
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERROR
   } state_t;

   state_t                state_reg, state_next;
   logic [1:0]            byte_idx_reg, byte_idx_next;
   logic [31:0]           word_reg, word_next;
   logic [CNT_W-1:0]      len_reg, len_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic [CNT_W-1:0]      cnt_inc;
   logic [31:0]           acc_reg, acc_next;

   logic                  in_ready_reg, in_ready_next;
   logic                  mem_we_reg, mem_we_next;
   logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
   logic [31:0]           mem_wdata_reg, mem_wdata_next;
   logic                  core_reset_reg, core_reset_next;
   logic                  done_reg, done_next;
   logic                  error_reg, error_next;

   logic                  accept;
   logic                  group_complete;
   logic [31:0]           group_word;

   // A byte moves only on a completed handshake; in_ready is the registered copy.
   assign accept         = in_valid && in_ready_reg;
   assign group_complete = accept && (byte_idx_reg == 2'd3);
   assign cnt_inc        = cnt_reg + CNT_W'(1);

   // Little-endian byte lanes: the lane selected by the byte index takes the
   // incoming byte, the others keep what was collected earlier in the group.
   // When the 4th byte arrives, group_word is the complete word.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign group_word[8*gi +: 8] = (byte_idx_reg == 2'(gi)) ? in_data
                                                                  : word_reg[8*gi +: 8];
      end
   endgenerate

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_next     = state_reg;
      byte_idx_next  = accept ? (byte_idx_reg + 2'd1) : byte_idx_reg;
      word_next      = accept ? group_word : word_reg;
      len_next       = len_reg;
      cnt_next       = cnt_reg;
      acc_next       = acc_reg;
      mem_we_next    = 1'b0;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;

      case (state_reg)
         ST_LEN: begin
            if (group_complete) begin
               if ((group_word == 32'd0) || (group_word > 32'(MAX_WORDS))) begin
                  state_next = ST_ERROR;
               end else begin
                  len_next   = CNT_W'(group_word);
                  state_next = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (group_complete) begin
               mem_we_next    = 1'b1;
               mem_addr_next  = ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(cnt_reg);
               mem_wdata_next = group_word;
               acc_next       = acc_reg + group_word;
               cnt_next       = cnt_inc;
               if (cnt_inc == len_reg) begin
                  state_next = ST_CSUM;
               end
            end
         end
         ST_CSUM: begin
            // The accumulator already includes the last data word, because it
            // was updated one group earlier.
            if (group_complete) begin
               state_next = (group_word == acc_reg) ? ST_DONE : ST_ERROR;
            end
         end
         default: begin
            // DONE and ERROR are terminal; in_ready is 0 so nothing moves.
         end
      endcase

      // Status outputs follow the state being entered, so done rises and
      // core_reset falls on the same edge.
      in_ready_next   = (state_next == ST_LEN) || (state_next == ST_DATA) ||
                        (state_next == ST_CSUM);
      done_next       = (state_next == ST_DONE);
      error_next      = (state_next == ST_ERROR);
      core_reset_next = (state_next != ST_DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg      <= ST_LEN;
         byte_idx_reg   <= 2'd0;
         word_reg       <= 32'd0;
         len_reg        <= '0;
         cnt_reg        <= '0;
         acc_reg        <= 32'd0;
         in_ready_reg   <= 1'b0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= ADDR_WIDTH'(START_ADDR);
         mem_wdata_reg  <= 32'd0;
         core_reset_reg <= 1'b1;
         done_reg       <= 1'b0;
         error_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         byte_idx_reg   <= byte_idx_next;
         word_reg       <= word_next;
         len_reg        <= len_next;
         cnt_reg        <= cnt_next;
         acc_reg        <= acc_next;
         in_ready_reg   <= in_ready_next;
         mem_we_reg     <= mem_we_next;
         mem_addr_reg   <= mem_addr_next;
         mem_wdata_reg  <= mem_wdata_next;
         core_reset_reg <= core_reset_next;
         done_reg       <= done_next;
         error_reg      <= error_next;
      end
   end

   assign in_ready   = in_ready_reg;
   assign mem_we     = mem_we_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_wdata  = mem_wdata_reg;
   assign core_reset = core_reset_reg;
   assign done       = done_reg;
   assign error      = error_reg;

endmodule
